// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Largest value representable in n decimal digits (n <= 8 fits in 32 bits).
   function automatic logic [31:0] max_decimal(input int unsigned n);
      logic [31:0] p;
      p = 32'd1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN_TO_BCD_LEADING_BLANK_EN to replace leading zero digits with the blank code.
module bin_to_bcd_converter
   import bcd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BIN_WIDTH  = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BIN_WIDTH-1:0]    bin_in,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    done,
   output logic                    overflow
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
   localparam int unsigned CMP_W = (BIN_WIDTH > 32) ? BIN_WIDTH : 32;

   state_t             r_state;
   state_t             w_next_state;
   logic               w_in_ready;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIN_WIDTH-1:0] r_shift;
   logic [BCD_W-1:0]   r_scratch;
   logic [BCD_W-1:0]   w_adj;
   logic               r_ovf_pend;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_ovf;
   logic               r_done;
   logic               w_accept;
   logic               w_too_big;

   function automatic logic [BCD_W-1:0] saturate_bcd();
      return {NUM_DIGITS{4'h9}};
   endfunction

   // Leading-zero blanking scans from the top digit down; units digit always shown.
   function automatic logic [BCD_W-1:0] format_bcd(input logic [BCD_W-1:0] d);
      logic [BCD_W-1:0] r;
      r = d;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
      begin
         logic seen;
         seen = 1'b0;
         for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (!seen && (d[4*i +: 4] == 4'd0)) begin
               r[4*i +: 4] = BCD_BLANK;
            end else begin
               seen = 1'b1;
            end
         end
      end
`endif
      return r;
   endfunction

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .i_digit (r_scratch[4*g +: 4]),
         .o_digit (w_adj[4*g +: 4])
      );
   end

   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_too_big = CMP_W'(bin_in) > CMP_W'(max_decimal(NUM_DIGITS));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_next_state = SHIFT;
         end
         SHIFT: begin
            if (r_cnt == CNT_W'(1)) w_next_state = DONE;
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_bcd  <= '0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_cnt <= CNT_W'(BIN_WIDTH);
         end else if (r_state == SHIFT) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (r_state == DONE) begin
            r_bcd  <= r_ovf_pend ? saturate_bcd() : format_bcd(r_scratch);
            r_ovf  <= r_ovf_pend;
            r_done <= 1'b1;
         end
      end
   end

   // Conversion datapath; carries out of the top digit fall off the shift
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_shift    <= bin_in;
         r_scratch  <= '0;
         r_ovf_pend <= w_too_big;
      end else if (r_state == SHIFT) begin
         r_shift   <= r_shift << 1;
         r_scratch <= (w_adj << 1) | BCD_W'(r_shift[BIN_WIDTH-1]);
      end
   end

   assign in_ready = w_in_ready;
   assign bcd_out  = r_bcd;
   assign done     = r_done;
   assign overflow = r_ovf;

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential double-dabble converter: accepts an unsigned binary value and produces NUM_DIGITS packed BCD digits.
- Sits directly upstream of the seven-segment display driver.
- Output is held stable between conversions, so the display multiplexer always sees a consistent value.
- Processes one binary bit per clock, trading latency for minimal logic.

Parameters:
- NUM_DIGITS, 4, number of BCD digits produced (1..8).
- BIN_WIDTH, 14, width of binary input; must be >= 1. Default equals the decimal-mode display data width for 4 digits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  converter can accept a new value.
- bin_in  input  BIN_WIDTH  unsigned binary value.
- bcd_out  output  4*NUM_DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- done  output  1  one-cycle pulse when bcd_out updates.
- overflow  output  1  last converted value exceeded 10**NUM_DIGITS-1; held with bcd_out.

Behaviour:
- Reset values: bcd_out = 0, done = 0, overflow = 0, in_ready = 1, state = IDLE.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, capture bin_in into the shift register, clear the BCD scratch register, load bit counter = BIN_WIDTH, compute the overflow flag, go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle:
    - every scratch digit >= 5 gets +3;
    - then {scratch, shift} shifts left by 1;
    - counter decrements.
    - When counter reaches 1 on this cycle, go to DONE.
  - DONE: in_ready = 0.
    - Register scratch into bcd_out and the overflow flag into overflow.
    - Assert done for exactly this one registered cycle.
    - Go to IDLE.
- Latency:
  - Acceptance edge T; SHIFT occupies BIN_WIDTH cycles.
  - bcd_out/done are visible after edge T+BIN_WIDTH+1.
  - Next acceptance is possible at edge T+BIN_WIDTH+2.
- Scratch register is 4*NUM_DIGITS bits; carries out of the top digit are discarded.
- Overflow handling:
  - If bin_in > 10**NUM_DIGITS-1, the result is saturated: bcd_out = all digits 9, overflow = 1.
  - Otherwise overflow = 0.
- bcd_out and overflow change only in DONE or on reset.
- in_valid while in_ready = 0 is ignored; no queuing, and bin_in is not sampled.
- Reset mid-conversion: the conversion is abandoned, and all outputs return to reset values on the next edge.
- If in_valid is held high continuously, a new conversion starts every BIN_WIDTH+2 cycles.

Optional Feature:
- Macro: BIN_TO_BCD_LEADING_BLANK_EN.
- Defined:
  - In DONE, every leading zero digit above the highest nonzero digit is replaced by 4'hF (blank code; the decimal-mode display decodes it as all segments off).
  - The units digit is never blanked.
  - Overflow saturation (all nines) has no leading zeros.
- Undefined: plain zero-padded BCD output.

Decomposition:
- Package bcd_pkg:
  - state enum typedef (IDLE, SHIFT, DONE);
  - constant BCD_BLANK = 4'hF;
  - function max_decimal(NUM_DIGITS) returning 10**NUM_DIGITS-1 for the overflow compare.
- Sub-module bcd_digit_adjust: combinational 4-bit "add 3 if >= 5", instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset, then bin_in = 1234 pulsed with in_valid → done exactly 15 cycles after the acceptance edge; bcd_out = 16'h1234; overflow = 0.
- bin_in = 0, then bin_in = 9999 → bcd_out = 16'h0000, then 16'h9999; one done pulse each.
- bin_in = 10000 → bcd_out = 16'h9999; overflow = 1. Next conversion of 5 → 16'h0005; overflow = 0.
- Pulse in_valid with 4321 while a conversion of 1111 is in SHIFT → ignored; bcd_out = 16'h1111; only one done.
- Assert rst at cycle 7 of a conversion of 8765 → bcd_out = 0, done never pulses, in_ready = 1 the next cycle. A fresh conversion then completes normally.
- With BIN_TO_BCD_LEADING_BLANK_EN defined:
  - 42 → 16'hFF42;
  - 0 → 16'hFFF0;
  - 1005 → 16'h1005.
